// File: rtl/tblink_rpc_ep_pkg.sv
// tblink_rpc_ep_pkg: shared header field positions and FSM encodings for the ring endpoint.
package tblink_rpc_ep_pkg;
    localparam int HDR_ADDR_MSB = 6;
    localparam int HDR_RSVD_BIT = 7;
    localparam logic [6:0] ADDR_RESERVED = 7'h0;
    typedef enum logic [2:0] {IN_IDLE, IN_FWD_CNT, IN_FWD_PAY, IN_TIP_CNT, IN_TIP_PAY} in_state_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_HDR, ARB_CNT, ARB_PAY} arb_state_t;
endpackage

// File: rtl/fw_rv_buffer.sv
// fw_rv_buffer: single forward-registered valid/ready stage, full throughput when downstream is ready.
module fw_rv_buffer #(
    parameter int W = 8
) (
    input  logic         uclock,
    input  logic         reset_n,
    input  logic [W-1:0] in_dat,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_dat,
    output logic         out_valid,
    input  logic         out_ready
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge uclock or negedge reset_n)
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_dat   <= in_dat;
        end
endmodule

// File: rtl/tblink_rpc_ep_arb.sv
// tblink_rpc_ep_arb: packet-locked round-robin arbiter over N byte streams with header/count/payload tracking.
module tblink_rpc_ep_arb
    import tblink_rpc_ep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           uclock,
    input  logic           reset_n,
    input  logic [8*N-1:0] req_dat,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     out_dat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);
    localparam int W = $clog2(N);
    arb_state_t state;
    logic [W-1:0] rr_ptr, grant, win, sel;
    logic [7:0] cnt;
    logic hs;
    always_comb begin
        win = rr_ptr;
        for (int i = N - 1; i >= 0; i--)
            if (req_valid[W'((int'(rr_ptr) + i) % N)]) win = W'((int'(rr_ptr) + i) % N);
    end
    // In IDLE the winner drives the ring directly so a header costs no extra cycle.
    assign sel       = (state == ARB_IDLE) ? win : grant;
    assign out_dat   = req_dat[8*sel +: 8];
    assign out_valid = req_valid[sel];
    assign req_ready = N'(out_ready) << sel;
    assign hs        = out_valid && out_ready;
    assign busy      = state != ARB_IDLE;
    always_ff @(posedge uclock or negedge reset_n)
        if (!reset_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (out_valid) begin
                    grant <= win;
                    state <= out_ready ? ARB_CNT : ARB_HDR;
                end
                ARB_HDR: if (hs) state <= ARB_CNT;
                ARB_CNT: if (hs) begin
                    cnt   <= out_dat;
                    state <= ARB_PAY;
                end
                ARB_PAY: if (hs) begin
                    cnt    <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                    state  <= (cnt == 8'd0) ? ARB_IDLE : ARB_PAY;
                    rr_ptr <= (cnt != 8'd0) ? rr_ptr : (grant == W'(N - 1)) ? '0 : grant + 1'b1;
                end
                default: state <= ARB_IDLE;
            endcase
        end
endmodule

// File: rtl/tblink_rpc_ep_mc.sv
// tblink_rpc_ep_mc: multi-channel ring endpoint; strips packets for local TIPs, forwards others, injects TIP traffic.
// Optional per-channel delivered-packet counters under TBLINK_RPC_EP_MC_STATS_EN.
module tblink_rpc_ep_mc
    import tblink_rpc_ep_pkg::*;
#(
    parameter int NUM_TIP   = 2,
    parameter int ADDR_BASE = 1
) (
    input  logic                 uclock,
    input  logic                 reset_n,
    input  logic                 hreq_i,
    output logic                 hreq_o,
    input  logic [7:0]           neti_dat,
    input  logic                 neti_valid,
    output logic                 neti_ready,
    output logic [7:0]           neto_dat,
    output logic                 neto_valid,
    input  logic                 neto_ready,
    output logic [8*NUM_TIP-1:0] tipo_dat,
    output logic [NUM_TIP-1:0]   tipo_valid,
    input  logic [NUM_TIP-1:0]   tipo_ready,
    input  logic [8*NUM_TIP-1:0] tipi_dat,
    input  logic [NUM_TIP-1:0]   tipi_valid,
    output logic [NUM_TIP-1:0]   tipi_ready
`ifdef TBLINK_RPC_EP_MC_STATS_EN
    ,output logic [16*NUM_TIP-1:0] stat_pkts
    ,input  logic                  stat_clr
`endif
);
    localparam int N = NUM_TIP + 1;
    if (NUM_TIP < 1 || NUM_TIP > 8 || ADDR_BASE <= int'(ADDR_RESERVED) || ADDR_BASE + NUM_TIP - 1 > 127
        || HDR_ADDR_MSB + 1 != HDR_RSVD_BIT) begin : g_bad_cfg
        $error("tblink_rpc_ep_mc: NUM_TIP must be 1..8 and ADDR_BASE..ADDR_BASE+NUM_TIP-1 within 1..127");
    end
    in_state_t state;
    logic [2:0] ch;
    logic [8:0] cnt;
    logic [6:0] dst, off;
    logic hit, is_tip, tsel_rdy, acc, arb_busy;
    logic pt_in_ready;
    logic [NUM_TIP-1:0] ti_valid, ti_ready;
    logic [N-1:0] av, ar;
    logic [8*N-1:0] ad;
    assign dst    = neti_dat[HDR_ADDR_MSB:0];
    assign off    = dst - 7'(ADDR_BASE);
    assign hit    = dst >= 7'(ADDR_BASE) && off < 7'(NUM_TIP);
    assign is_tip = state == IN_TIP_CNT || state == IN_TIP_PAY;
    always_comb begin
        tsel_rdy = 1'b0;
        for (int i = 0; i < NUM_TIP; i++) if (ch == 3'(i)) tsel_rdy = ti_ready[i];
    end
    // Local headers are gated by the pass-through buffer too, keeping neti_ready state-only.
    assign neti_ready = is_tip ? tsel_rdy : pt_in_ready;
    assign acc        = neti_valid && neti_ready;
    assign hreq_o     = hreq_i | (state != IN_IDLE) | arb_busy;
    always_ff @(posedge uclock or negedge reset_n)
        if (!reset_n) begin
            state <= IN_IDLE;
            ch    <= '0;
            cnt   <= '0;
        end else if (acc) begin
            case (state)
                IN_IDLE: begin
                    state <= hit ? IN_TIP_CNT : IN_FWD_CNT;
                    ch    <= off[2:0];
                end
                IN_FWD_CNT, IN_TIP_CNT: begin
                    cnt   <= {1'b0, neti_dat};
                    state <= (state == IN_FWD_CNT) ? IN_FWD_PAY : IN_TIP_PAY;
                end
                IN_FWD_PAY, IN_TIP_PAY: begin
                    cnt   <= (cnt == 9'd0) ? 9'd0 : cnt - 9'd1;
                    state <= (cnt == 9'd0) ? IN_IDLE : state;
                end
                default: state <= IN_IDLE;
            endcase
        end
    fw_rv_buffer #(.W(8)) u_pt (
        .uclock(uclock), .reset_n(reset_n),
        .in_dat(neti_dat), .in_valid(neti_valid && (state == IN_IDLE ? !hit : !is_tip)), .in_ready(pt_in_ready),
        .out_dat(ad[7:0]), .out_valid(av[0]), .out_ready(ar[0])
    );
    for (genvar k = 0; k < NUM_TIP; k++) begin : g_tip
        assign ti_valid[k] = neti_valid && is_tip && ch == 3'(k);
        fw_rv_buffer #(.W(8)) u_tipo (
            .uclock(uclock), .reset_n(reset_n),
            .in_dat(neti_dat), .in_valid(ti_valid[k]), .in_ready(ti_ready[k]),
            .out_dat(tipo_dat[8*k +: 8]), .out_valid(tipo_valid[k]), .out_ready(tipo_ready[k])
        );
        fw_rv_buffer #(.W(8)) u_tipi (
            .uclock(uclock), .reset_n(reset_n),
            .in_dat(tipi_dat[8*k +: 8]), .in_valid(tipi_valid[k]), .in_ready(tipi_ready[k]),
            .out_dat(ad[8*k+8 +: 8]), .out_valid(av[k+1]), .out_ready(ar[k+1])
        );
`ifdef TBLINK_RPC_EP_MC_STATS_EN
        // Tracks count/payload framing on tipo[k] to spot the last payload byte.
        logic ph, ths;
        logic [7:0] pc;
        logic [15:0] pkts;
        assign ths = tipo_valid[k] && tipo_ready[k];
        assign stat_pkts[16*k +: 16] = pkts;
        always_ff @(posedge uclock or negedge reset_n)
            if (!reset_n) begin
                ph   <= 1'b0;
                pc   <= '0;
                pkts <= '0;
            end else begin
                if (ths) begin
                    ph <= ph ? pc != 8'd0 : 1'b1;
                    pc <= ph ? pc - 8'd1 : tipo_dat[8*k +: 8];
                end
                pkts <= stat_clr ? 16'd0 : (ths && ph && pc == 8'd0 && pkts != 16'hFFFF) ? pkts + 16'd1 : pkts;
            end
`endif
    end
    tblink_rpc_ep_arb #(.N(N)) u_arb (
        .uclock(uclock), .reset_n(reset_n),
        .req_dat(ad), .req_valid(av), .req_ready(ar),
        .out_dat(neto_dat), .out_valid(neto_valid), .out_ready(neto_ready),
        .busy(arb_busy)
    );
endmodule
